// File: rtl/ccc_lock_reset_sequencer_pkg.sv
// Shared definitions for the RC oscillator -> CCC PLL reset sequencer.
// Contents:
//   ccc_state_e       3-bit state encoding, also driven on the STATE debug port
//   DEF_*             default cycle constants for the sequencer parameters
//   ccc_clog2         ceil(log2(value)), used to size counters
//   ccc_retry_w       width of the retry counter (never below 1)
//   ccc_max5          maximum of five cycle parameters
package ccc_lock_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE    = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_FABRIC    = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } ccc_state_e;

  localparam int DEF_SETTLE_CYCLES       = 256;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_CORE_DELAY_CYCLES   = 32;
  localparam int DEF_MAX_RETRY           = 3;

  function automatic int ccc_clog2(input int value);
    int result;
    result = 0;
    while ((longint'(1) << result) < longint'(value)) begin
      result++;
    end
    return result;
  endfunction

  function automatic int ccc_retry_w(input int max_retry);
    return (ccc_clog2(max_retry + 1) < 1) ? 1 : ccc_clog2(max_retry + 1);
  endfunction

  function automatic int ccc_max5(input int a, input int b, input int c,
                                  input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/ccc_lock_reset_sequencer_lock_sync.sv
// lock_sync: two-flop synchroniser for an asynchronous status input.
// Both flops reset asynchronously to 0, so a status input reads as "not
// asserted" until two clean edges have passed after reset release.
// Ports:
//   i_clk    sampling clock
//   i_rst    asynchronous active-high reset
//   i_async  asynchronous status input
//   o_sync   synchronised copy (two-cycle latency)
module lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/ccc_lock_reset_sequencer.sv
// ccc_lock_reset_sequencer: power-up and lock-recovery sequencer for the
// RC oscillator -> CCC PLL clock path. Holds the PLL in reset while the
// oscillator settles, waits for a stable lock (with per-attempt timeout and
// bounded retries), then releases fabric and core resets in order.
// Ports:
//   i_clk             RC oscillator clock (only clock)
//   i_reset           asynchronous active-high reset (POR/device init)
//   i_pll_lock        CCC lock, asynchronous to i_clk
//   i_soft_restart    single-cycle restart request
//   o_ccc_pll_arst_n  PLL reset, active-low
//   o_fabric_reset_n  peripheral reset, active-low
//   o_core_reset_n    CPU reset, active-low
//   o_ready           high only in RUN
//   o_fault           high only in FAULT
//   o_retry_count     timeout retries used in the current sequence
//   o_state           debug state code (ccc_state_e)
module ccc_lock_reset_sequencer
  import ccc_lock_reset_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES       = DEF_SETTLE_CYCLES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int CORE_DELAY_CYCLES   = DEF_CORE_DELAY_CYCLES,
  parameter int MAX_RETRY           = DEF_MAX_RETRY
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_pll_lock,
  input  logic                                i_soft_restart,
  output logic                                o_ccc_pll_arst_n,
  output logic                                o_fabric_reset_n,
  output logic                                o_core_reset_n,
  output logic                                o_ready,
  output logic                                o_fault,
  output logic [ccc_retry_w(MAX_RETRY)-1:0]   o_retry_count,
  output logic [2:0]                          o_state
);

  localparam int CNT_W   = ccc_clog2(ccc_max5(SETTLE_CYCLES, PLL_RST_CYCLES,
                                              LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                              CORE_DELAY_CYCLES) + 1);
  localparam int RETRY_W = ccc_retry_w(MAX_RETRY);

  // Counters are loaded with N-1 on entry and the exit fires when they read
  // 0, so a state entered at edge e leaves at edge e+N.
  localparam logic [CNT_W-1:0]   L_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   L_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   L_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   L_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   L_CORE    = CNT_W'(CORE_DELAY_CYCLES - 1);
  localparam logic [RETRY_W-1:0] L_MAX_RETRY = RETRY_W'(MAX_RETRY);

  logic w_lock_s;

  lock_sync u_lock_sync (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_async (i_pll_lock),
    .o_sync  (w_lock_s)
  );

  ccc_state_e         r_state, w_next_state;
  logic [CNT_W-1:0]   r_phase, w_phase_next;
  logic [CNT_W-1:0]   r_timeout, w_timeout_next;
  logic [RETRY_W-1:0] r_retry, w_retry_next;
  logic               w_in_lock_wait;
  logic               r_arst_n, r_fabric_n, r_core_n, r_ready, r_fault;
  logic               w_arst_n_next, w_fabric_n_next, w_core_n_next;
  logic               w_ready_next, w_fault_next;

  assign w_in_lock_wait = (r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE);

  always_comb begin
    w_next_state   = r_state;
    w_phase_next   = (r_phase == '0) ? '0 : r_phase - CNT_W'(1);
    w_timeout_next = r_timeout;
    w_retry_next   = r_retry;

    if (w_in_lock_wait && (r_timeout != '0)) begin
      w_timeout_next = r_timeout - CNT_W'(1);
    end

    if (i_soft_restart && (r_state != ST_SETTLE)) begin
      w_next_state = ST_PLL_RST;
      w_phase_next = L_PLL_RST;
      w_retry_next = '0;
    end else if (w_in_lock_wait && (r_timeout == '0)) begin
      if (r_retry == L_MAX_RETRY) begin
        w_next_state = ST_FAULT;
      end else begin
        w_next_state = ST_PLL_RST;
        w_phase_next = L_PLL_RST;
        w_retry_next = r_retry + RETRY_W'(1);
      end
    end else begin
      unique case (r_state)
        ST_SETTLE: begin
          if (r_phase == '0) begin
            w_next_state = ST_PLL_RST;
            w_phase_next = L_PLL_RST;
          end
        end
        ST_PLL_RST: begin
          if (r_phase == '0) begin
            w_next_state   = ST_WAIT_LOCK;
            w_timeout_next = L_TIMEOUT;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next_state = ST_STABLE;
            w_phase_next = L_STABLE;
          end
        end
        ST_STABLE: begin
          // A low lock sample on the last stable cycle still counts as lost.
          if (!w_lock_s) begin
            w_next_state = ST_WAIT_LOCK;
          end else if (r_phase == '0) begin
            w_next_state = ST_FABRIC;
            w_phase_next = L_CORE;
          end
        end
        ST_FABRIC: begin
          if (!w_lock_s) begin
            w_next_state = ST_PLL_RST;
            w_phase_next = L_PLL_RST;
          end else if (r_phase == '0) begin
            w_next_state = ST_RUN;
            w_retry_next = '0;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_next_state = ST_PLL_RST;
            w_phase_next = L_PLL_RST;
          end
        end
        ST_FAULT: begin
          w_next_state = ST_FAULT;
        end
        default: begin
          w_next_state = ST_SETTLE;
          w_phase_next = L_SETTLE;
        end
      endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    w_arst_n_next   = !((w_next_state == ST_SETTLE) || (w_next_state == ST_PLL_RST) ||
                        (w_next_state == ST_FAULT));
    w_fabric_n_next = (w_next_state == ST_FABRIC) || (w_next_state == ST_RUN);
    w_core_n_next   = (w_next_state == ST_RUN);
    w_ready_next    = (w_next_state == ST_RUN);
    w_fault_next    = (w_next_state == ST_FAULT);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_SETTLE;
      r_phase    <= L_SETTLE;
      r_timeout  <= '0;
      r_retry    <= '0;
      r_arst_n   <= 1'b0;
      r_fabric_n <= 1'b0;
      r_core_n   <= 1'b0;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_phase    <= w_phase_next;
      r_timeout  <= w_timeout_next;
      r_retry    <= w_retry_next;
      r_arst_n   <= w_arst_n_next;
      r_fabric_n <= w_fabric_n_next;
      r_core_n   <= w_core_n_next;
      r_ready    <= w_ready_next;
      r_fault    <= w_fault_next;
    end
  end

  assign o_ccc_pll_arst_n = r_arst_n;
  assign o_fabric_reset_n = r_fabric_n;
  assign o_core_reset_n   = r_core_n;
  assign o_ready          = r_ready;
  assign o_fault          = r_fault;
  assign o_retry_count    = r_retry;
  assign o_state          = r_state;

endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// Directed bench for ccc_lock_reset_sequencer with small cycle parameters:
// SETTLE=4, PLL_RST=2, LOCK_STABLE=3, TIMEOUT=10, CORE_DELAY=2, MAX_RETRY=1.
// Edge numbers are counted from reset deassertion (edge 1 is the first
// rising clock edge after release); outputs are sampled 1 ns after an edge.
module tb_ccc_lock_reset_sequencer;

  localparam int S_SETTLE = 0;
  localparam int S_PLLRST = 1;
  localparam int S_WAIT   = 2;
  localparam int S_STABLE = 3;
  localparam int S_FABRIC = 4;
  localparam int S_RUN    = 5;
  localparam int S_FAULT  = 6;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       soft_restart;
  logic       arst_n;
  logic       fabric_n;
  logic       core_n;
  logic       ready;
  logic       fault;
  logic [0:0] retry;
  logic [2:0] state;

  int n_total;
  int n_bad;
  int edge_n;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ccc_lock_reset_sequencer #(
    .SETTLE_CYCLES       (4),
    .PLL_RST_CYCLES      (2),
    .LOCK_STABLE_CYCLES  (3),
    .LOCK_TIMEOUT_CYCLES (10),
    .CORE_DELAY_CYCLES   (2),
    .MAX_RETRY           (1)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_pll_lock       (pll_lock),
    .i_soft_restart   (soft_restart),
    .o_ccc_pll_arst_n (arst_n),
    .o_fabric_reset_n (fabric_n),
    .o_core_reset_n   (core_n),
    .o_ready          (ready),
    .o_fault          (fault),
    .o_retry_count    (retry),
    .o_state          (state)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (edge %0d): got %0d expected %0d", tag, edge_n, got, exp);
    end
  endtask

  // Checks the full output set against one expected vector.
  task automatic chk_all(input string tag, input int e_state, input logic e_arst,
                         input logic e_fab, input logic e_core, input logic e_ready,
                         input logic e_fault, input int e_retry);
    chk({tag, ".state"},  32'(state),    32'(e_state));
    chk({tag, ".arst_n"}, 32'(arst_n),   32'(e_arst));
    chk({tag, ".fab_n"},  32'(fabric_n), 32'(e_fab));
    chk({tag, ".core_n"}, 32'(core_n),   32'(e_core));
    chk({tag, ".ready"},  32'(ready),    32'(e_ready));
    chk({tag, ".fault"},  32'(fault),    32'(e_fault));
    chk({tag, ".retry"},  32'(retry),    32'(e_retry));
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic lock);
    rst          = 1'b1;
    soft_restart = 1'b0;
    pll_lock     = lock;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
    #1;
  endtask

  task automatic goto_edge(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    n_total      = 0;
    n_bad        = 0;
    edge_n       = 0;
    rst          = 1'b1;
    pll_lock     = 1'b0;
    soft_restart = 1'b0;

    // Lock high from start.
    start_run(1'b1);
    chk_all("s1_reset", S_SETTLE, 0, 0, 0, 0, 0, 0);
    goto_edge(3);  chk("s1_e3_state", 32'(state), S_SETTLE);
    goto_edge(4);  chk_all("s1_e4", S_PLLRST, 0, 0, 0, 0, 0, 0);
    goto_edge(5);  chk("s1_e5_arst", 32'(arst_n), 0);
    goto_edge(6);  chk_all("s1_e6", S_WAIT, 1, 0, 0, 0, 0, 0);
    goto_edge(7);  chk("s1_e7_state", 32'(state), S_STABLE);
    goto_edge(9);  chk("s1_e9_fab", 32'(fabric_n), 0);
    goto_edge(10); chk_all("s1_e10", S_FABRIC, 1, 1, 0, 0, 0, 0);
    goto_edge(11); chk("s1_e11_core", 32'(core_n), 0);
    goto_edge(12); chk_all("s1_e12", S_RUN, 1, 1, 1, 1, 0, 0);

    // Reset mid-FABRIC, then soft restart ignored in SETTLE.
    start_run(1'b1);
    goto_edge(10); chk("s6_e10_state", 32'(state), S_FABRIC);
    #2 rst = 1'b1;
    #1 chk_all("s6_async", S_SETTLE, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
    #1;
    goto_edge(1);  soft_restart = 1'b1;
    goto_edge(2);  soft_restart = 1'b0;
    chk_all("s6_soft_ign", S_SETTLE, 0, 0, 0, 0, 0, 0);
    goto_edge(3);  chk("s6_e3_state", 32'(state), S_SETTLE);
    goto_edge(4);  chk("s6_e4_state", 32'(state), S_PLLRST);

    // Lock tied low: one retry, then FAULT.
    start_run(1'b0);
    goto_edge(15); chk_all("s2_e15", S_WAIT, 1, 0, 0, 0, 0, 0);
    goto_edge(16); chk_all("s2_e16", S_PLLRST, 0, 0, 0, 0, 0, 1);
    goto_edge(17); chk("s2_e17_arst", 32'(arst_n), 0);
    goto_edge(18); chk_all("s2_e18", S_WAIT, 1, 0, 0, 0, 0, 1);
    goto_edge(27); chk("s2_e27_fault", 32'(fault), 0);
    goto_edge(28); chk_all("s2_e28", S_FAULT, 0, 0, 0, 0, 1, 1);
    goto_edge(30); chk_all("s2_e30", S_FAULT, 0, 0, 0, 0, 1, 1);

    // Recovery from FAULT via soft restart with lock high.
    pll_lock     = 1'b1;
    soft_restart = 1'b1;
    goto_edge(31); soft_restart = 1'b0;
    chk_all("s5_e31", S_PLLRST, 0, 0, 0, 0, 0, 0);
    goto_edge(33); chk("s5_e33_state", 32'(state), S_WAIT);
    goto_edge(34); chk("s5_e34_state", 32'(state), S_STABLE);
    goto_edge(38); chk("s5_e38_ready", 32'(ready), 0);
    goto_edge(39); chk_all("s5_e39", S_RUN, 1, 1, 1, 1, 0, 0);

    // Reset discards a nonzero retry count.
    start_run(1'b0);
    goto_edge(17); chk("s6b_e17_retry", 32'(retry), 1);
    #2 rst = 1'b1;
    #1 chk_all("s6b_async", S_SETTLE, 0, 0, 0, 0, 0, 0);

    // One-cycle lock glitch while STABLE.
    start_run(1'b1);
    goto_edge(5);  pll_lock = 1'b0;
    goto_edge(6);  pll_lock = 1'b1;
    goto_edge(7);  chk("s3_e7_state", 32'(state), S_STABLE);
    goto_edge(8);  chk("s3_e8_state", 32'(state), S_WAIT);
    goto_edge(9);  chk("s3_e9_state", 32'(state), S_STABLE);
    goto_edge(11); chk_all("s3_e11", S_STABLE, 1, 0, 0, 0, 0, 0);
    goto_edge(12); chk("s3_e12_state", 32'(state), S_FABRIC);
    goto_edge(13); chk("s3_e13_ready", 32'(ready), 0);
    goto_edge(14); chk_all("s3_e14", S_RUN, 1, 1, 1, 1, 0, 0);

    // Lock loss in RUN, then rerun to RUN.
    goto_edge(16); pll_lock = 1'b0;
    goto_edge(18); chk_all("s4_e18", S_RUN, 1, 1, 1, 1, 0, 0);
    goto_edge(19); chk_all("s4_e19", S_PLLRST, 0, 0, 0, 0, 0, 0);
    pll_lock = 1'b1;
    goto_edge(21); chk_all("s4_e21", S_WAIT, 1, 0, 0, 0, 0, 0);
    goto_edge(22); chk("s4_e22_state", 32'(state), S_STABLE);
    goto_edge(25); chk("s4_e25_state", 32'(state), S_FABRIC);
    goto_edge(26); chk("s4_e26_ready", 32'(ready), 0);
    goto_edge(27); chk_all("s4_e27", S_RUN, 1, 1, 1, 1, 0, 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
